// File: rtl/morse_digit_tx.sv
// Morse keyer for digits 0-9: five timed marks, then a character gap; Start taken only while ReadyY=1.
// MY rises 1 clock after accept; DoneY closes the character gap, and ErrY flags an accepted Start with D>9.
module morse_digit_tx #(
  parameter int TICK_DIV = 12500000,
  parameter int DOT_T    = 2,
  parameter int DASH_T   = 5,
  parameter int EL_GAP_T = 2,
  parameter int CH_GAP_T = 8
) (
  input  logic       C,
  input  logic       R,
  input  logic [3:0] D,
  input  logic       Start,
  output logic       ReadyY,
  output logic       MY,
  output logic       DoneY,
  output logic       ErrY
);

  localparam int TW   = $clog2(TICK_DIV);
  localparam int MAXT = (DASH_T > CH_GAP_T) ? DASH_T : CH_GAP_T;
  localparam int DW   = $clog2(MAXT + 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, CHGAP} state_t;

  state_t        state;
  logic [TW-1:0] tickCnt;
  logic [DW-1:0] durCnt;
  logic [DW-1:0] durLast;
  logic [4:0]    pat;
  logic [2:0]    elIdx;
  logic          tickLast;
  logic          elemDone;

  // Dashes fill the tail for 0-5 and the head for 6-9; bit 4 is sent first.
  function automatic logic [4:0] digitPattern(input logic [3:0] d);
    logic [5:0] ones;
    if (d <= 4'd5) begin
      ones = (6'd1 << (4'd5 - d)) - 6'd1;
      return ones[4:0];
    end
    ones = (6'd1 << (4'd10 - d)) - 6'd1;
    return ~ones[4:0];
  endfunction

  always_comb begin
    durLast = '0;
    case (state)
      MARK:    durLast = pat[4] ? DW'(DASH_T - 1) : DW'(DOT_T - 1);
      SPACE:   durLast = DW'(EL_GAP_T - 1);
      CHGAP:   durLast = DW'(CH_GAP_T - 1);
      default: durLast = '0;
    endcase
  end

  assign tickLast = (tickCnt == TW'(TICK_DIV - 1));
  assign elemDone = tickLast && (durCnt == durLast);

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state   <= IDLE;
      tickCnt <= '0;
      durCnt  <= '0;
      pat     <= '0;
      elIdx   <= '0;
      MY      <= 1'b0;
      ReadyY  <= 1'b1;
      DoneY   <= 1'b0;
      ErrY    <= 1'b0;
    end else begin
      DoneY <= 1'b0;
      ErrY  <= 1'b0;
      // Counters restart on every state change so each element is an exact multiple of T.
      if (state != IDLE) begin
        if (elemDone) begin
          tickCnt <= '0;
          durCnt  <= '0;
        end else if (tickLast) begin
          tickCnt <= '0;
          durCnt  <= durCnt + DW'(1);
        end else begin
          tickCnt <= tickCnt + TW'(1);
        end
      end
      case (state)
        IDLE: begin
          if (Start) begin
            if (D <= 4'd9) begin
              pat    <= digitPattern(D);
              elIdx  <= '0;
              state  <= MARK;
              MY     <= 1'b1;
              ReadyY <= 1'b0;
            end else begin
              ErrY <= 1'b1;
            end
          end
        end
        MARK: begin
          if (elemDone) begin
            MY    <= 1'b0;
            state <= (elIdx == 3'd4) ? CHGAP : SPACE;
          end
        end
        SPACE: begin
          if (elemDone) begin
            MY    <= 1'b1;
            elIdx <= elIdx + 3'd1;
            pat   <= {pat[3:0], 1'b0};
            state <= MARK;
          end
        end
        CHGAP: begin
          if (elemDone) begin
            DoneY  <= 1'b1;
            ReadyY <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_digit_tx.sv
// Scoreboarded bench for morse_digit_tx: the driver queues expected characters, the monitor measures the keying line.
module tb_morse_digit_tx;

  localparam int TD   = 4;
  localparam int DOT  = 2;
  localparam int DASH = 5;
  localparam int EL   = 2;
  localparam int CH   = 8;

  logic       C, R, Start;
  logic [3:0] D;
  logic       ReadyY, MY, DoneY, ErrY;

  morse_digit_tx #(.TICK_DIV(TD), .DOT_T(DOT), .DASH_T(DASH), .EL_GAP_T(EL), .CH_GAP_T(CH)) dut (
    .C(C), .R(R), .D(D), .Start(Start),
    .ReadyY(ReadyY), .MY(MY), .DoneY(DoneY), .ErrY(ErrY)
  );

  typedef struct packed {
    logic            isErr;
    logic            b2b;
    logic [3:0]      digit;
    logic [4:0][7:0] marks;
    logic [15:0]     total;
  } exp_t;

  exp_t q[$];
  int   nChecks = 0;
  int   nFails  = 0;

  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  task automatic check(input string name, input int act, input int req);
    nChecks++;
    if (act != req) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic failNow(input string name);
    nChecks++;
    nFails++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Standard Morse digits: 0 is all dashes, 1-5 start with d dots, 6-9 start with d-5 dashes.
  function automatic exp_t model(input int d, input bit b2b);
    exp_t e;
    int   sum;
    bit   dash;
    e       = '0;
    sum     = 0;
    e.digit = d[3:0];
    e.b2b   = b2b;
    if (d > 9) begin
      e.isErr = 1'b1;
      return e;
    end
    for (int i = 0; i < 5; i++) begin
      if (d == 0)      dash = 1'b1;
      else if (d <= 5) dash = (i >= d);
      else             dash = (i < d - 5);
      e.marks[i] = 8'((dash ? DASH : DOT) * TD);
      sum += (dash ? DASH : DOT) * TD;
    end
    e.total = 16'(sum + (4 * EL + CH) * TD);
    return e;
  endfunction

  // Monitor: measures marks/spaces, total time and b2b restart; checks against the queue head.
  int   cyc = 0;
  int   runLen = 0;
  int   startCyc = 0;
  int   lastDone = -100;
  int   markIdx = 0;
  int   marksSeen[5];
  bit   inChar = 0;
  logic prevMY = 1'b0;
  exp_t e;

  always @(posedge C) begin
    #1;
    cyc++;
    if (R) begin
      inChar = 0;
      runLen = 0;
      markIdx = 0;
      prevMY = 1'b0;
    end else begin
      if (MY && !prevMY) begin
        if (!inChar) begin
          inChar   = 1;
          startCyc = cyc;
          markIdx  = 0;
          if (q.size() == 0) failNow("unexpected mark");
          else if (q[0].b2b) check("b2b start gap", cyc - lastDone, 1);
        end else begin
          check("space len", runLen, EL * TD);
        end
        runLen = 1;
      end else if (!MY && prevMY) begin
        if (markIdx < 5) marksSeen[markIdx] = runLen;
        markIdx++;
        runLen = 1;
      end else begin
        runLen++;
      end
      prevMY = MY;

      if (DoneY) begin
        lastDone = cyc;
        if (q.size() == 0) failNow("unexpected DoneY");
        else begin
          e = q.pop_front();
          check("DoneY on error digit", int'(e.isErr), 0);
          check("mark count", markIdx, 5);
          for (int i = 0; i < 5; i++)
            check($sformatf("digit %0d mark %0d len", e.digit, i), marksSeen[i], int'(e.marks[i]));
          check($sformatf("digit %0d accept->DoneY", e.digit), cyc - startCyc, int'(e.total));
          check("ReadyY with DoneY", int'(ReadyY), 1);
        end
        inChar = 0;
      end

      if (ErrY) begin
        if (q.size() == 0) failNow("unexpected ErrY");
        else begin
          e = q.pop_front();
          check($sformatf("ErrY for digit %0d", e.digit), int'(e.isErr), 1);
          check("MY during ErrY", int'(MY), 0);
          check("ReadyY during ErrY", int'(ReadyY), 1);
        end
      end
    end
  end

  task automatic waitReady();
    int n = 0;
    @(negedge C);
    while (!ReadyY && n < 1000) begin
      @(negedge C);
      n++;
    end
    if (!ReadyY) failNow("ReadyY timeout");
  endtask

  task automatic sendDigit(input int d);
    waitReady();
    D     = 4'(d);
    Start = 1'b1;
    @(posedge C);
    q.push_back(model(d, 1'b0));
    @(negedge C);
    Start = 1'b0;
    D     = 4'($urandom);
  endtask

  task automatic pulseIgnored(input int waitCyc);
    repeat (waitCyc) @(negedge C);
    if (!ReadyY) begin
      D     = 4'($urandom);
      Start = 1'b1;
      @(negedge C);
      Start = 1'b0;
    end
  endtask

  initial begin
    int n;
    int d;
    R = 1'b1;
    Start = 1'b0;
    D = 4'd0;
    repeat (3) @(negedge C);
    check("reset MY", int'(MY), 0);
    check("reset ReadyY", int'(ReadyY), 1);
    check("reset DoneY", int'(DoneY), 0);
    check("reset ErrY", int'(ErrY), 0);
    R = 1'b0;

    // Reset in the middle of a mark abandons the character immediately.
    sendDigit(0);
    repeat (6) @(negedge C);
    check("MY before mid-mark reset", int'(MY), 1);
    @(posedge C);
    #3 R = 1'b1;
    #1;
    check("MY after async reset", int'(MY), 0);
    check("ReadyY after async reset", int'(ReadyY), 1);
    q.delete();
    repeat (3) @(negedge C);
    R = 1'b0;

    sendDigit(0);
    sendDigit(5);
    sendDigit(7);
    sendDigit(12);
    check("ReadyY after error", int'(ReadyY), 1);
    sendDigit(9);
    D = 4'd3;
    pulseIgnored(30);

    // 9 then 3 with Start held high throughout.
    waitReady();
    D = 4'd9;
    Start = 1'b1;
    @(posedge C);
    q.push_back(model(9, 1'b0));
    @(negedge C);
    D = 4'd3;
    q.push_back(model(3, 1'b1));
    n = 0;
    while (!ReadyY && n < 1000) begin
      @(negedge C);
      n++;
    end
    if (!ReadyY) failNow("b2b ReadyY timeout");
    @(negedge C);
    Start = 1'b0;

    for (int i = 0; i < 30; i++) begin
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      sendDigit(d);
      if (d <= 9 && $urandom_range(0, 1) == 1) pulseIgnored(int'($urandom_range(1, 100)));
    end
    for (int i = 0; i < 10; i++) sendDigit(i);

    n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(negedge C);
      n++;
    end
    check("scoreboard drained", q.size(), 0);
    repeat (5) @(negedge C);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
